// File: rtl/cpu_controller_if.sv
// Bus bundle between the CPU sequencer and its datapath.
// master = controller (drives strobes/status), slave = datapath/debug side.
interface cpu_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic [2:0]           op_code;
  logic                 zero;
  logic                 step_mode;
  logic                 step;
  logic                 resume;
  logic                 sel;
  logic                 rd;
  logic                 ld_ir;
  logic                 inc_pc;
  logic                 ld_pc;
  logic                 ld_ac;
  logic                 wr;
  logic                 data_e;
  logic                 halt;
  logic [2:0]           phase;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  op_code, zero, step_mode, step, resume,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
    output halt, phase, instr_count
  );

  modport slave (
    output op_code, zero, step_mode, step, resume,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e,
    input  halt, phase, instr_count
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer with halt/resume, single-step and a
// retired-instruction counter; strobes decode from registered phase.
module cpu_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_controller_if.master  bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  phase_e               phase_q, phase_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic aluop, is_skz, is_sto, is_jmp, is_hlt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    aluop  = bus.op_code inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    is_skz = bus.op_code == OP_SKZ;
    is_sto = bus.op_code == OP_STO;
    is_jmp = bus.op_code == OP_JMP;
    is_hlt = bus.op_code == OP_HLT;

    phase_d  = phase_q;
    halted_d = halted_q;
    count_d  = count_q;

    // Halt outranks the step wait; a resume re-enters at ALU_OP so the
    // HLT instruction still retires through STORE.
    if (halted_q) begin
      if (bus.resume) begin
        halted_d = 1'b0;
        phase_d  = ALU_OP;
      end
    end else if (phase_q == INST_ADDR && bus.step_mode && !bus.step) begin
      phase_d = INST_ADDR;
    end else if (phase_q == OP_ADDR && is_hlt) begin
      halted_d = 1'b1;
      phase_d  = OP_FETCH;
    end else begin
      phase_d = phase_e'(phase_q + 3'd1);
      if (phase_q == STORE) count_d = count_q + 1'b1;
    end

    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;

    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR:  bus.inc_pc = 1'b1;
        OP_FETCH: bus.rd     = aluop;
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_pc  = is_jmp;
          bus.ld_ac  = aluop;
          bus.data_e = is_sto;
          bus.wr     = is_sto;
        end
        default: ;
      endcase
    end

    bus.halt        = halted_q;
    bus.phase       = phase_q;
    bus.instr_count = count_q;
  end

endmodule
